// File: rtl/parallel_data_receiver.sv
// Parallel data receiver: four-phase req/ack capture into a DEPTH-entry FIFO with a valid/rd_en read port.
// Optional even-parity checking on incoming words is enabled with `define PDR_PARITY_EN.
//
// state    | meaning
// ST_IDLE  | ack low, waiting for req with room in the FIFO
// ST_ACKED | word taken (or rejected on parity), ack high until req drops
module parallel_data_receiver #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req,
   input  logic [WIDTH-1:0]         data_in,
   output logic                     ack,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         data_out,
   output logic                     valid,
   output logic [$clog2(DEPTH):0]   count
`ifdef PDR_PARITY_EN
   ,
   input  logic                     parity_in,
   output logic                     parity_err
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {ST_IDLE, ST_ACKED} state_t;

   state_t            r_state;
   logic              r_ack;
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [WIDTH-1:0]  r_mem [DEPTH];

   logic w_not_empty;
   logic w_room;
   logic w_accept;
   logic w_store;
   logic w_pop;

   assign w_not_empty = (r_count != '0);
   assign w_room      = (r_count < CW'(DEPTH));
   assign w_accept    = (r_state == ST_IDLE) && req && w_room;
   assign w_pop       = rd_en && w_not_empty;

`ifdef PDR_PARITY_EN
   logic r_parity_err;
   logic w_parity_ok;

   // even parity: parity_in makes the total XOR of data_in and parity_in zero
   assign w_parity_ok = (parity_in == ^data_in);
   assign w_store     = w_accept && w_parity_ok;
   assign parity_err  = r_parity_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_parity_err <= 1'b0;
      end else if (w_accept && !w_parity_ok) begin
         r_parity_err <= 1'b1;
      end
   end
`else
   assign w_store = w_accept;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_ack    <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_ack   <= 1'b1;
                  r_state <= ST_ACKED;
               end else begin
                  r_ack   <= 1'b0;
               end
            end
            ST_ACKED: begin
               if (!req) begin
                  r_ack   <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_ack   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase

         if (w_store) begin
            r_mem[r_wr_ptr] <= data_in;
            r_wr_ptr        <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end

         case ({w_store, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign ack      = r_ack;
   assign valid    = w_not_empty;
   assign count    = r_count;
   assign data_out = w_not_empty ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_parallel_data_receiver.sv
// Self-checking bench for parallel_data_receiver: directed handshake/FIFO scenarios, then randomized traffic
// checked every cycle against a queue-based reference model. Parity cases run when PDR_PARITY_EN is defined.
module tb_parallel_data_receiver;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   req;
   logic [WIDTH-1:0]       data_in;
   logic                   ack;
   logic                   rd_en;
   logic [WIDTH-1:0]       data_out;
   logic                   valid;
   logic [$clog2(DEPTH):0] count;
`ifdef PDR_PARITY_EN
   logic                   parity_in;
   logic                   parity_err;
`endif

   int checks   = 0;
   int failures = 0;

   logic [WIDTH-1:0] q[$];
   logic             m_ack;
   logic             m_perr;
   int               rd_bias;

   always #5 clk = ~clk;

   parallel_data_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .data_in  (data_in),
      .ack      (ack),
      .rd_en    (rd_en),
      .data_out (data_out),
      .valid    (valid),
      .count    (count)
`ifdef PDR_PARITY_EN
      ,
      .parity_in  (parity_in),
      .parity_err (parity_err)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input logic [WIDTH-1:0] w);
      data_in = w;
`ifdef PDR_PARITY_EN
      parity_in = ^w;
`endif
   endtask

   // Reference model: a plain queue plus the handshake rules, advanced once per rising edge.
   task automatic model_edge();
      logic acc;
      logic pop;
      logic ok;
      if (rst) begin
         q.delete();
         m_ack  = 1'b0;
         m_perr = 1'b0;
      end else begin
         ok = 1'b1;
`ifdef PDR_PARITY_EN
         ok = (parity_in == ^data_in);
`endif
         acc = !m_ack && req && (q.size() < DEPTH);
         pop = rd_en && (q.size() > 0);
         if (pop) void'(q.pop_front());
         if (acc && ok) q.push_back(data_in);
         if (acc && !ok) m_perr = 1'b1;
         if (acc) m_ack = 1'b1;
         else if (m_ack && !req) m_ack = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("ack", 32'(ack), 32'(m_ack));
      chk("count", 32'(count), 32'(q.size()));
      chk("valid", 32'(valid), 32'(q.size() > 0));
      chk("data_out", 32'(data_out), (q.size() > 0) ? 32'(q[0]) : 32'd0);
`ifdef PDR_PARITY_EN
      chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
   endtask

   task automatic send(input logic [WIDTH-1:0] w);
      int n;
      set_data(w);
      req = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!ack && n < 40);
      chk("send_ack_timeout", 32'(ack), 32'd1);
      req = 1'b0;
      step();
   endtask

   task automatic pop_one();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; rd_en = 1'b0; data_in = '0;
`ifdef PDR_PARITY_EN
      parity_in = 1'b0;
`endif
      m_ack = 1'b0; m_perr = 1'b0;

      // reset, then a single word
      step(); step();
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      rst = 1'b0;
      set_data(4'hA); req = 1'b1;
      step();
      chk("t1_ack", 32'(ack), 32'd1);
      chk("t1_data", 32'(data_out), 32'hA);
      chk("t1_count", 32'(count), 32'd1);
      req = 1'b0;
      step();
      chk("t1_ack_drop", 32'(ack), 32'd0);
      pop_one();
      chk("t1_valid_after_pop", 32'(valid), 32'd0);
      chk("t1_data_after_pop", 32'(data_out), 32'd0);

      // fill to full, stall, pop releases the stalled word a cycle later
      send(4'h1); send(4'h2); send(4'h3); send(4'h4);
      chk("t2_full_count", 32'(count), 32'd4);
      set_data(4'h5); req = 1'b1;
      repeat (3) step();
      chk("t2_full_no_ack", 32'(ack), 32'd0);
      pop_one();
      chk("t2_pop_no_ack_yet", 32'(ack), 32'd0);
      chk("t2_pop_count", 32'(count), 32'd3);
      step();
      chk("t2_late_ack", 32'(ack), 32'd1);
      chk("t2_late_count", 32'(count), 32'd4);
      req = 1'b0;
      step();
      for (int i = 2; i <= 5; i++) begin
         chk("t2_drain", 32'(data_out), 32'(i));
         pop_one();
      end
      chk("t2_empty", 32'(valid), 32'd0);

      // simultaneous accept and pop across pointer wrap
      send(4'h6); send(4'h7);
      set_data(4'h8); req = 1'b1; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("t3_count", 32'(count), 32'd2);
      chk("t3_head", 32'(data_out), 32'h7);
      req = 1'b0;
      step();
      pop_one();
      chk("t3_second", 32'(data_out), 32'h8);
      pop_one();

      // reset while in ACKED with three words stored
      send(4'h9); send(4'hA);
      set_data(4'hB); req = 1'b1;
      step();
      chk("t4_three", 32'(count), 32'd3);
      rst = 1'b1; set_data(4'hC);
      step();
      chk("t4_rst_ack", 32'(ack), 32'd0);
      chk("t4_rst_count", 32'(count), 32'd0);
      chk("t4_rst_valid", 32'(valid), 32'd0);
      rst = 1'b0;
      step();
      chk("t4_fresh_ack", 32'(ack), 32'd1);
      chk("t4_fresh_data", 32'(data_out), 32'hC);
      req = 1'b0;
      step();
      pop_one();

      // empty read, then req stuck high for 10 cycles
      pop_one();
      chk("t5_empty_count", 32'(count), 32'd0);
      set_data(4'hD); req = 1'b1;
      repeat (10) step();
      chk("t5_stuck_count", 32'(count), 32'd1);
      req = 1'b0;
      step();
      pop_one();

`ifdef PDR_PARITY_EN
      data_in = 4'h3; parity_in = 1'b1; req = 1'b1;
      step();
      chk("p_bad_ack", 32'(ack), 32'd1);
      chk("p_bad_count", 32'(count), 32'd0);
      chk("p_err", 32'(parity_err), 32'd1);
      req = 1'b0;
      step();
      send(4'h3);
      chk("p_good_count", 32'(count), 32'd1);
      chk("p_err_sticky", 32'(parity_err), 32'd1);
      pop_one();
`endif

      // randomized traffic
      rd_bias = 50;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 500 == 0) rd_bias = (cyc / 500) % 3 == 0 ? 15 : ((cyc / 500) % 3 == 1 ? 50 : 85);
         rst = ($urandom_range(0, 299) == 0);
         if (req && m_ack) begin
            if ($urandom_range(0, 2) != 0) req = 1'b0;
         end else if (!req && !m_ack) begin
            if ($urandom_range(0, 1) == 1) begin
               req = 1'b1;
               set_data(WIDTH'($urandom));
`ifdef PDR_PARITY_EN
               if ($urandom_range(0, 19) == 0) parity_in = ~parity_in;
`endif
            end
         end
         rd_en = ($urandom_range(0, 99) < rd_bias);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
